// File: rtl/pixel_adjust_engine.sv
`default_nettype none
// ============================================================================
// Module      : pixel_adjust_engine
// Description : Frame-buffered point-operation engine. A LOAD phase stores one
//               WIDTH x HEIGHT frame of CH-channel pixels through a valid/ready
//               port. A PROC phase streams the frame back out with a
//               per-channel saturating adjustment under downstream
//               backpressure.
// Ports       : clk, rst (async, active-high)
//               start_load, in_valid, in_ready, in_data     - frame load port
//               start_proc, mode, bright, gain              - processing control
//               out_valid, out_ready, out_data, out_last    - output stream
//               busy, finish                                - status
// Modes       : 00 pass, 01 brighten (saturating add), 10 darken (floor at 0),
//               11 invert, or contrast when PIXADJ_CONTRAST_EN is defined.
// Config      : `define PIXADJ_CONTRAST_EN builds mode 11 as
//               min((s*gain)>>4, max) with gain in unsigned 4.4 fixed point.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_adjust_engine #(
    parameter int DW     = 8,
    parameter int CH     = 1,
    parameter int WIDTH  = 410,
    parameter int HEIGHT = 361
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_load,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_data,
    input  logic             start_proc,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    bright,
    input  logic [7:0]       gain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             finish
);

    localparam int c_TOTAL = WIDTH * HEIGHT;
    localparam int c_AW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    // Read pointer needs one extra code point: it parks at TOTAL once the
    // final pixel has been fetched, while that pixel waits to be accepted.
    localparam int c_PW    = $clog2(c_TOTAL + 1);

    localparam logic [c_AW-1:0] c_WR_LAST = c_AW'(c_TOTAL - 1);
    localparam logic [c_PW-1:0] c_RD_LAST = c_PW'(c_TOTAL - 1);
    localparam logic [c_PW-1:0] c_RD_END  = c_PW'(c_TOTAL);
    localparam logic [DW-1:0]   c_MAX     = '1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_PROC = 2'd2;

    logic [1:0]       r_state;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [1:0]       r_mode;
    logic [DW-1:0]    r_bright;
    logic             r_out_valid;
    logic [CH*DW-1:0] r_out_data;
    logic             r_out_last;
    logic             r_finish;

    logic [CH*DW-1:0] r_buf [c_TOTAL];

    logic             w_wr_en;
    logic             w_advance;
    logic             w_done;
    logic [CH*DW-1:0] w_rd_pix;
    logic [CH*DW-1:0] w_adj;

`ifdef PIXADJ_CONTRAST_EN
    logic [7:0]       r_gain;
`else
    logic             w_unused_gain;
    assign w_unused_gain = ^gain;
`endif

    assign in_ready  = (r_state == c_ST_LOAD);
    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign finish    = r_finish;

    assign w_wr_en   = (r_state == c_ST_LOAD) && in_valid;
    // Completion takes priority; rd_ptr already sits at END then, so the
    // two conditions can never both fire anyway.
    assign w_done    = (r_state == c_ST_PROC) && r_out_valid && out_ready && r_out_last;
    assign w_advance = (r_state == c_ST_PROC) && (r_rd_ptr < c_RD_END) &&
                       (!r_out_valid || out_ready);

    // Asynchronous buffer read; the index is out of range only while parked
    // at END, when the value is never used.
    assign w_rd_pix  = r_buf[r_rd_ptr[c_AW-1:0]];

    // Frame storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr] <= in_data;
        end
    end

    // Per-channel point operation, DW+1-bit intermediates expose carry/borrow.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [DW-1:0] w_s;
        logic [DW:0]   w_sum;
        logic [DW:0]   w_diff;
        logic [DW-1:0] w_op11;
        logic [DW-1:0] w_res;

        assign w_s    = w_rd_pix[g*DW +: DW];
        assign w_sum  = {1'b0, w_s} + {1'b0, r_bright};
        assign w_diff = {1'b0, w_s} - {1'b0, r_bright};

`ifdef PIXADJ_CONTRAST_EN
        logic [DW+7:0] w_prod;
        logic          w_unused_frac;
        assign w_prod        = (DW+8)'(w_s) * (DW+8)'(r_gain);
        assign w_unused_frac = ^w_prod[3:0];
        // Drop the 4 fractional bits; any set bit above DW after that saturates.
        assign w_op11 = (|w_prod[DW+7:DW+4]) ? c_MAX : w_prod[DW+3:4];
`else
        assign w_op11 = c_MAX - w_s;
`endif

        always_comb begin
            w_res = w_s;
            case (r_mode)
                2'b01:   w_res = w_sum[DW] ? c_MAX : w_sum[DW-1:0];
                2'b10:   w_res = w_diff[DW] ? '0 : w_diff[DW-1:0];
                2'b11:   w_res = w_op11;
                default: w_res = w_s;
            endcase
        end

        assign w_adj[g*DW +: DW] = w_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mode      <= 2'b00;
            r_bright    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_finish    <= 1'b0;
`ifdef PIXADJ_CONTRAST_EN
            r_gain      <= 8'd0;
`endif
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // start_load wins when both starts arrive together.
                    if (start_load) begin
                        r_state <= c_ST_LOAD;
                    end else if (start_proc) begin
                        r_state  <= c_ST_PROC;
                        r_mode   <= mode;
                        r_bright <= bright;
`ifdef PIXADJ_CONTRAST_EN
                        r_gain   <= gain;
`endif
                    end
                end
                c_ST_LOAD: begin
                    if (in_valid) begin
                        if (r_wr_ptr == c_WR_LAST) begin
                            r_wr_ptr <= '0;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_AW'(1);
                        end
                    end
                end
                c_ST_PROC: begin
                    if (w_done) begin
                        r_finish    <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_rd_ptr    <= '0;
                        r_state     <= c_ST_IDLE;
                    end else if (w_advance) begin
                        r_out_data  <= w_adj;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_rd_ptr == c_RD_LAST);
                        r_rd_ptr    <= r_rd_ptr + c_PW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_adjust_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pixel_adjust_engine
// Description : Directed self-checking bench for pixel_adjust_engine. One
//               instance is a 4x5 single-channel frame, a second is a 2x1
//               three-channel frame for per-channel arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_adjust_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int r_errors = 0;
    int r_checks = 0;
    int r_exp [20];

    // 4x5, CH=1 instance
    logic        r_start_load, r_in_valid, r_start_proc, r_out_ready;
    logic [7:0]  r_in_data, r_bright, r_gain;
    logic [1:0]  r_mode;
    logic        w_in_ready, w_out_valid, w_out_last, w_busy, w_finish;
    logic [7:0]  w_out_data;

    // 2x1, CH=3 instance
    logic        r3_start_load, r3_in_valid, r3_start_proc, r3_out_ready;
    logic [23:0] r3_in_data;
    logic [7:0]  r3_bright, r3_gain;
    logic [1:0]  r3_mode;
    logic        w3_in_ready, w3_out_valid, w3_out_last, w3_busy, w3_finish;
    logic [23:0] w3_out_data;

    pixel_adjust_engine #(.DW(8), .CH(1), .WIDTH(4), .HEIGHT(5)) u_dut (
        .clk(clk), .rst(rst),
        .start_load(r_start_load), .in_valid(r_in_valid), .in_ready(w_in_ready),
        .in_data(r_in_data), .start_proc(r_start_proc), .mode(r_mode),
        .bright(r_bright), .gain(r_gain), .out_valid(w_out_valid),
        .out_ready(r_out_ready), .out_data(w_out_data), .out_last(w_out_last),
        .busy(w_busy), .finish(w_finish)
    );

    pixel_adjust_engine #(.DW(8), .CH(3), .WIDTH(2), .HEIGHT(1)) u_dut3 (
        .clk(clk), .rst(rst),
        .start_load(r3_start_load), .in_valid(r3_in_valid), .in_ready(w3_in_ready),
        .in_data(r3_in_data), .start_proc(r3_start_proc), .mode(r3_mode),
        .bright(r3_bright), .gain(r3_gain), .out_valid(w3_out_valid),
        .out_ready(r3_out_ready), .out_data(w3_out_data), .out_last(w3_out_last),
        .busy(w3_busy), .finish(w3_finish)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1();
        r_start_load = 1'b1;
        tick();
        r_start_load = 1'b0;
        check("load_in_ready", 32'(w_in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            r_in_valid = 1'b1;
            r_in_data  = 8'(i);
            tick();
        end
        r_in_valid = 1'b0;
        check("load_end_in_ready", 32'(w_in_ready), 32'd0);
        check("load_end_busy", 32'(w_busy), 32'd0);
    endtask

    // Streams the whole frame, compares against r_exp, checks stall stability,
    // out_last placement and a single finish pulse.
    task automatic proc1(input logic [1:0] m, input logic [7:0] b, input logic [7:0] g,
                         input bit toggle);
        int         n    = 0;
        int         fins = 0;
        int         post = 0;
        bit         have_hold = 0;
        bit         rdy;
        logic [7:0] hold = 8'd0;
        logic       hold_last = 1'b0;
        r_mode = m; r_bright = b; r_gain = g;
        r_start_proc = 1'b1;
        tick();
        r_start_proc = 1'b0;
        check("proc_entry_valid", 32'(w_out_valid), 32'd0);
        check("proc_entry_busy", 32'(w_busy), 32'd1);
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            if (have_hold) begin
                check("stall_data", 32'(w_out_data), 32'(hold));
                check("stall_last", 32'(w_out_last), 32'(hold_last));
                have_hold = 0;
            end
            if (w_finish) fins++;
            if (w_out_valid) begin
                if (rdy) begin
                    if (n < 20) begin
                        check("beat_data", 32'(w_out_data), 32'(r_exp[n]));
                        check("beat_last", 32'(w_out_last), 32'(n == 19));
                    end
                    n++;
                end else begin
                    hold = w_out_data; hold_last = w_out_last; have_hold = 1;
                end
            end
            r_out_ready = rdy;
            if (fins > 0) post++;
            if (post == 3) break;
            tick();
        end
        r_out_ready = 1'b0;
        check("beat_count", 32'(n), 32'd20);
        check("finish_pulses", 32'(fins), 32'd1);
        check("done_busy", 32'(w_busy), 32'd0);
        check("done_valid", 32'(w_out_valid), 32'd0);
    endtask

    task automatic load3(input logic [23:0] p0, input logic [23:0] p1);
        r3_start_load = 1'b1;
        tick();
        r3_start_load = 1'b0;
        r3_in_valid = 1'b1;
        r3_in_data  = p0;
        tick();
        r3_in_data  = p1;
        tick();
        r3_in_valid = 1'b0;
        check("ch3_load_end_ready", 32'(w3_in_ready), 32'd0);
    endtask

    task automatic proc3(input string tag, input logic [1:0] m, input logic [7:0] b,
                         input logic [7:0] g, input logic [23:0] e0, input logic [23:0] e1);
        int n = 0;
        r3_mode = m; r3_bright = b; r3_gain = g;
        r3_start_proc = 1'b1;
        tick();
        r3_start_proc = 1'b0;
        r3_out_ready  = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (w3_out_valid) begin
                check(tag, 32'(w3_out_data), 32'((n == 0) ? e0 : e1));
                n++;
            end
            if (w3_finish) break;
            tick();
        end
        r3_out_ready = 1'b0;
        check("ch3_beat_count", 32'(n), 32'd2);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        r_start_load = 0; r_in_valid = 0; r_start_proc = 0; r_out_ready = 0;
        r_in_data = 0; r_bright = 0; r_gain = 0; r_mode = 0;
        r3_start_load = 0; r3_in_valid = 0; r3_start_proc = 0; r3_out_ready = 0;
        r3_in_data = 0; r3_bright = 0; r3_gain = 0; r3_mode = 0;
        repeat (3) tick();
        check("rst_in_ready", 32'(w_in_ready), 32'd0);
        check("rst_out_valid", 32'(w_out_valid), 32'd0);
        check("rst_out_data", 32'(w_out_data), 32'd0);
        check("rst_out_last", 32'(w_out_last), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_finish", 32'(w_finish), 32'd0);
        rst = 1'b0;
        tick();

        // Brighten with saturation
        load1();
        for (int i = 0; i < 20; i++) r_exp[i] = (i + 240 > 255) ? 255 : i + 240;
        proc1(2'b01, 8'd240, 8'd0, 1'b0);

        // Darken with floor at zero
        for (int i = 0; i < 20; i++) r_exp[i] = (i < 5) ? 0 : i - 5;
        proc1(2'b10, 8'd5, 8'd0, 1'b0);

        // Pass-through under alternating backpressure
        for (int i = 0; i < 20; i++) r_exp[i] = i;
        proc1(2'b00, 8'd0, 8'd0, 1'b1);

        // Mode 11 over the ramp frame
`ifdef PIXADJ_CONTRAST_EN
        for (int i = 0; i < 20; i++) r_exp[i] = (i * 24) / 16;
`else
        for (int i = 0; i < 20; i++) r_exp[i] = 255 - i;
`endif
        proc1(2'b11, 8'd0, 8'h18, 1'b0);

        // Three-channel arithmetic
        load3({8'd250, 8'd10, 8'd128}, {8'd200, 8'd100, 8'd0});
        proc3("ch3_brighten", 2'b01, 8'd10, 8'h00,
              {8'd255, 8'd20, 8'd138}, {8'd210, 8'd110, 8'd10});
`ifdef PIXADJ_CONTRAST_EN
        proc3("ch3_mode11", 2'b11, 8'd0, 8'h18,
              {8'd255, 8'd15, 8'd192}, {8'd255, 8'd150, 8'd0});
`else
        proc3("ch3_mode11", 2'b11, 8'd0, 8'h18,
              {8'd5, 8'd245, 8'd127}, {8'd55, 8'd155, 8'd255});
`endif

        // Reset in the middle of PROC, after 7 accepted beats
        r_mode = 2'b00; r_bright = 0;
        r_start_proc = 1'b1;
        tick();
        r_start_proc = 1'b0;
        r_out_ready  = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 7; cyc++) begin
            if (w_out_valid) n++;
            if (n < 7) tick();
        end
        check("abort_beats_seen", 32'(n), 32'd7);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(w_out_valid), 32'd0);
        check("abort_busy", 32'(w_busy), 32'd0);
        check("abort_out_data", 32'(w_out_data), 32'd0);
        r_out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) r_exp[i] = i;
        proc1(2'b00, 8'd0, 8'd0, 1'b0);

        // Simultaneous starts: load takes precedence
        r_start_load = 1'b1;
        r_start_proc = 1'b1;
        tick();
        r_start_load = 1'b0;
        r_start_proc = 1'b0;
        check("both_start_in_ready", 32'(w_in_ready), 32'd1);
        check("both_start_out_valid", 32'(w_out_valid), 32'd0);
        tick();
        check("both_start_no_output", 32'(w_out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
